// File: rtl/uart_baud_gen_frac_if.sv
// Interface between the baud generator and its register/UART neighbours.
// The generator uses the slave modport. The register block or bench uses master.
// With UART_BAUD_RX_RESYNC_EN defined, the receiver resync handshake is included.
interface uart_baud_gen_frac_if #(
    parameter int unsigned CNTR_WIDTH = 16,
    parameter int unsigned FRAC_WIDTH = 4,
    parameter int unsigned OVS_LOG2   = 4
);
    logic                  enable;
    logic [CNTR_WIDTH-1:0] baud_val;
    logic [FRAC_WIDTH-1:0] baud_frac;
    logic                  baud_tick;
    logic                  xmit_pulse;
    logic [OVS_LOG2-1:0]   tick_phase;
`ifdef UART_BAUD_RX_RESYNC_EN
    logic                  rx_resync;
    logic                  rx_sample_pulse;
`endif

    modport master (
        output enable, baud_val, baud_frac,
`ifdef UART_BAUD_RX_RESYNC_EN
        output rx_resync,
        input  rx_sample_pulse,
`endif
        input  baud_tick, xmit_pulse, tick_phase
    );

    modport slave (
        input  enable, baud_val, baud_frac,
`ifdef UART_BAUD_RX_RESYNC_EN
        input  rx_resync,
        output rx_sample_pulse,
`endif
        output baud_tick, xmit_pulse, tick_phase
    );
endinterface

// File: rtl/uart_baud_gen_frac.sv
// Fractional baud generator with an oversampled tick and a per-bit transmit pulse.
// The base tick period is baud_val+1 clocks.
// A FRAC_WIDTH-bit accumulator adds one stretch cycle on every carry.
// Optional macro UART_BAUD_RX_RESYNC_EN adds an rx mid-bit sample phase counter.
module uart_baud_gen_frac #(
    parameter int unsigned CNTR_WIDTH = 16,
    parameter int unsigned FRAC_WIDTH = 4,
    parameter int unsigned OVS_LOG2   = 4
) (
    input  logic clk,
    input  logic reset_n,
    uart_baud_gen_frac_if.slave bus
);
    localparam int unsigned OVS = 1 << OVS_LOG2;
    localparam logic [OVS_LOG2-1:0] PHASE_LAST = OVS_LOG2'(OVS - 1);
    localparam logic [OVS_LOG2-1:0] PHASE_ONE  = OVS_LOG2'(1);
    localparam logic [CNTR_WIDTH-1:0] CNTR_ONE = CNTR_WIDTH'(1);

    logic [CNTR_WIDTH-1:0] baud_cntr_r, baud_cntr_s;
    logic [FRAC_WIDTH-1:0] frac_acc_r,  frac_acc_s;
    logic                  stretch_r,   stretch_s;
    logic                  baud_tick_r, baud_tick_s;
    logic [OVS_LOG2-1:0]   tick_phase_r, tick_phase_s;
    logic [FRAC_WIDTH:0]   acc_sum_s;

    // Next-state logic for the divider: count down, optional stretch cycle, reload with tick.
    always_comb begin
        baud_cntr_s = baud_cntr_r;
        frac_acc_s  = frac_acc_r;
        stretch_s   = stretch_r;
        baud_tick_s = 1'b0;
        acc_sum_s   = {1'b0, frac_acc_r} + {1'b0, bus.baud_frac};
        if (!bus.enable) begin
            baud_cntr_s = '0;
            frac_acc_s  = '0;
            stretch_s   = 1'b0;
        end else if (baud_cntr_r != '0) begin
            baud_cntr_s = baud_cntr_r - CNTR_ONE;
        end else if (stretch_r) begin
            stretch_s = 1'b0;
        end else begin
            // Divisor and fraction are sampled only here, so a live change never truncates a period.
            baud_cntr_s = bus.baud_val;
            baud_tick_s = 1'b1;
            frac_acc_s  = acc_sum_s[FRAC_WIDTH-1:0];
            stretch_s   = acc_sum_s[FRAC_WIDTH];
        end
    end

    // Next-state logic for the oversample phase: it advances in the clock after each visible tick.
    always_comb begin
        tick_phase_s = tick_phase_r;
        if (!bus.enable) begin
            tick_phase_s = '0;
        end else if (baud_tick_r) begin
            tick_phase_s = tick_phase_r + PHASE_ONE;
        end else begin
            tick_phase_s = tick_phase_r;
        end
    end

    // State registers for the divider and the phase counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            baud_cntr_r  <= '0;
            frac_acc_r   <= '0;
            stretch_r    <= 1'b0;
            baud_tick_r  <= 1'b0;
            tick_phase_r <= '0;
        end else begin
            baud_cntr_r  <= baud_cntr_s;
            frac_acc_r   <= frac_acc_s;
            stretch_r    <= stretch_s;
            baud_tick_r  <= baud_tick_s;
            tick_phase_r <= tick_phase_s;
        end
    end

    assign bus.baud_tick  = baud_tick_r;
    assign bus.tick_phase = tick_phase_r;
    // Decoded only from registers, so the pulse is glitch-free and fires on every OVS-th tick.
    assign bus.xmit_pulse = baud_tick_r & (tick_phase_r == PHASE_LAST);

`ifdef UART_BAUD_RX_RESYNC_EN
    localparam logic [OVS_LOG2-1:0] RX_MID = OVS_LOG2'(OVS / 2 - 1);

    logic [OVS_LOG2-1:0] rx_phase_r, rx_phase_s;

    // Next-state logic for the rx phase: resync wins over a coincident tick.
    always_comb begin
        rx_phase_s = rx_phase_r;
        if (!bus.enable) begin
            rx_phase_s = '0;
        end else if (bus.rx_resync) begin
            rx_phase_s = '0;
        end else if (baud_tick_r) begin
            rx_phase_s = rx_phase_r + PHASE_ONE;
        end else begin
            rx_phase_s = rx_phase_r;
        end
    end

    // The rx phase register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_phase_r <= '0;
        end else begin
            rx_phase_r <= rx_phase_s;
        end
    end

    assign bus.rx_sample_pulse = baud_tick_r & (rx_phase_r == RX_MID);
`endif
endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// Directed bench for uart_baud_gen_frac.
// Expected tick times, transmit pulses and phases are queued when stimulus starts.
// They are popped and compared as each tick appears.
module tb_uart_baud_gen_frac;
    localparam int CW = 16;
    localparam int FW = 3;
    localparam int OL = 4;

    typedef struct {
        int         cyc;
        logic       xmit;
        logic [3:0] phase;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    int   cyc = 0;
    int   t0 = 0;
    int   passed = 0;
    int   total = 0;
    exp_t exp_q[$];
    int   obs[$];

    always #5 clk = ~clk;

    // Free-running cycle counter used to time-stamp ticks.
    always @(posedge clk) cyc <= cyc + 1;

    uart_baud_gen_frac_if #(.CNTR_WIDTH(CW), .FRAC_WIDTH(FW), .OVS_LOG2(OL)) bus();

    uart_baud_gen_frac #(.CNTR_WIDTH(CW), .FRAC_WIDTH(FW), .OVS_LOG2(OL)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    endtask

    // Waits (bounded) for the next negedge at which baud_tick is high.
    task automatic wait_tick(output int c, output bit ok);
        ok = 1'b0;
        c  = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.baud_tick === 1'b1) begin
                ok = 1'b1;
                c  = cyc - t0;
                break;
            end
        end
    endtask

    // Called at a negedge: loads the divisors and raises enable.
    task automatic start(input int val, input int frac);
        bus.baud_val  = CW'(val);
        bus.baud_frac = FW'(frac);
        bus.enable    = 1'b1;
        t0            = cyc;
        obs.delete();
    endtask

    task automatic stop();
        bus.enable = 1'b0;
        @(negedge clk);
    endtask

    // Expected ticks from enable rise: the spacing is val+1, plus one after a fractional carry.
    task automatic push_model(input int val, input int frac, input int n);
        int t;
        int acc;
        int sum;
        t   = 1;
        acc = 0;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{t, ((i % 16) == 15), 4'(i % 16)});
            sum = acc + frac;
            t   = t + val + 1 + ((sum >= 8) ? 1 : 0);
            acc = sum % 8;
        end
    endtask

    task automatic push_one(input int c, input logic x, input int ph);
        exp_q.push_back('{c, x, 4'(ph)});
    endtask

    // Pops every queued expectation and compares it against the next observed tick.
    task automatic collect();
        exp_t e;
        int   c;
        bit   ok;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_tick(c, ok);
            if (!ok) begin
                check("tick_timeout", 32'd0, 32'd1);
                exp_q.delete();
                break;
            end
            obs.push_back(c);
            check("tick_cycle", c, e.cyc);
            check("xmit_pulse", bus.xmit_pulse, e.xmit);
            check("tick_phase", bus.tick_phase, e.phase);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_tick"}, bus.baud_tick, 1'b0);
        check({tag, "_xmit"}, bus.xmit_pulse, 1'b0);
        check({tag, "_phase"}, bus.tick_phase, 4'd0);
    endtask

    function automatic int count_long(input int n);
        int cnt;
        cnt = 0;
        for (int i = 1; i < n; i++) begin
            if (obs.size() > i && (obs[i] - obs[i-1]) == 5) cnt++;
        end
        return cnt;
    endfunction

    initial begin
        int  c;
        bit  ok;
        reset_n       = 1'b0;
        bus.enable    = 1'b0;
        bus.baud_val  = '0;
        bus.baud_frac = '0;
`ifdef UART_BAUD_RX_RESYNC_EN
        bus.rx_resync = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check_idle("reset");
        reset_n = 1'b1;
        @(negedge clk);
        check_idle("disabled");

        // Integer divisor: ticks every 4 clocks, xmit on ticks 16 and 32 (cycles 61 and 125).
        start(3, 0);
        push_model(3, 0, 32);
        collect();
        check("int_xmit16_cycle", (obs.size() > 15) ? obs[15] : -1, 61);
        stop();
        check_idle("enable_low");

        // Half fraction: spacings alternate 4,5 and eight ticks span 36 clocks.
        start(3, 4);
        push_model(3, 4, 9);
        collect();
        check("frac4_span", (obs.size() > 8) ? obs[8] - obs[0] : -1, 36);
        stop();

        // Fraction 1/8: exactly one long spacing, after the 8th tick.
        start(3, 1);
        push_model(3, 1, 9);
        collect();
        check("frac1_long", count_long(9), 1);
        stop();

        // Fraction 7/8: seven long spacings out of eight.
        start(3, 7);
        push_model(3, 7, 9);
        collect();
        check("frac7_long", count_long(9), 7);
        stop();

        // Degenerate divisor: a tick every clock and xmit every 16 clocks.
        start(0, 0);
        push_model(0, 0, 33);
        collect();
        repeat (2) @(negedge clk);
        check("cont_tick", bus.baud_tick, 1'b1);
        check("cont_phase", bus.tick_phase, 4'd2);
        // Asynchronous reset in mid-cycle, with no clock edge in between.
        #2 reset_n = 1'b0;
        #1 check_idle("async_reset");
        bus.enable = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Live divisor change 3->7: the current period still ends at 4 clocks, then periods are 8.
        start(3, 0);
        push_one(1, 1'b0, 0);
        collect();
        @(negedge clk);
        bus.baud_val = CW'(7);
        push_one(5, 1'b0, 1);
        push_one(13, 1'b0, 2);
        push_one(21, 1'b0, 3);
        collect();
        stop();

        // Enable drop just before a due tick with frac_acc != 0: no tick, and history is lost.
        start(3, 4);
        push_one(1, 1'b0, 0);
        collect();
        repeat (3) @(negedge clk);
        bus.enable = 1'b0;
        @(negedge clk);
        check_idle("enable_drop");
        start(3, 4);
        push_model(3, 4, 5);
        collect();
        stop();

`ifdef UART_BAUD_RX_RESYNC_EN
        // Resync coincident with a tick: mid-bit pulse on the 8th following tick.
        start(1, 0);
        wait_tick(c, ok);
        wait_tick(c, ok);
        check("rx_pre_tick", ok, 1'b1);
        bus.rx_resync = 1'b1;
        @(posedge clk);
        #1 bus.rx_resync = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            wait_tick(c, ok);
            check("rx_sample_a", bus.rx_sample_pulse, (i == 8));
        end
        // A second resync between ticks restarts the count.
        @(negedge clk);
        bus.rx_resync = 1'b1;
        @(posedge clk);
        #1 bus.rx_resync = 1'b0;
        for (int j = 1; j <= 26; j++) begin
            wait_tick(c, ok);
            check("rx_sample_b", bus.rx_sample_pulse, (j == 8 || j == 24));
        end
        stop();
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
